// File: rtl/ldpc_iter_sched_if.sv
// ---------------------------------------------------------------------------
// ldpc_iter_sched_if
//   Handshake and phase-control bundle between the LDPC iteration scheduler
//   and its environment (frame source, phase engines, result sink).
//
//   Handshake semantics (both pairs): a transfer happens on a rising clock
//   edge where valid and ready are both high. Valid, once raised, is held
//   until that transfer. Ready may toggle freely.
//     frame request : i_val (source)    / o_rdy (scheduler)
//     result        : o_val (scheduler) / i_rdy (sink)
//
//   Phase engines see only single-cycle *_start pulses and answer with
//   *_done pulses. i_parity_ok is meaningful only together with i_est_done.
//
//   Modports
//     slave  : the scheduler side (drives o_*, reads i_*)
//     master : the environment side (drives i_*, reads o_*)
//
//   Optional feature macro: ITER_SCHED_WDOG_EN adds o_wdog.
//   o_dbg_state exposes the scheduler state register for observation.
// ---------------------------------------------------------------------------
interface ldpc_iter_sched_if;
  logic       i_val;
  logic       o_rdy;
  logic       o_load_start;
  logic       i_load_done;
  logic       o_row_start;
  logic       i_row_done;
  logic       o_est_start;
  logic       i_est_done;
  logic       i_parity_ok;
  logic       o_col_start;
  logic       i_col_done;
  logic       o_val;
  logic       i_rdy;
  logic [6:0] o_loop;
  logic       o_fail;
  logic [2:0] o_dbg_state;
`ifdef ITER_SCHED_WDOG_EN
  logic       o_wdog;
`endif

  modport slave (
`ifdef ITER_SCHED_WDOG_EN
    output o_wdog,
`endif
    input  i_val, i_load_done, i_row_done, i_est_done, i_parity_ok,
    input  i_col_done, i_rdy,
    output o_rdy, o_load_start, o_row_start, o_est_start, o_col_start,
    output o_val, o_loop, o_fail, o_dbg_state
  );

  modport master (
`ifdef ITER_SCHED_WDOG_EN
    input  o_wdog,
`endif
    output i_val, i_load_done, i_row_done, i_est_done, i_parity_ok,
    output i_col_done, i_rdy,
    input  o_rdy, o_load_start, o_row_start, o_est_start, o_col_start,
    input  o_val, o_loop, o_fail, o_dbg_state
  );
endinterface

// File: rtl/ldpc_iter_sched.sv
// ---------------------------------------------------------------------------
// ldpc_iter_sched
//   Iteration scheduler of the min-sum LDPC decoder. Accepts one frame, then
//   runs LOAD -> {ROW -> EST -> COL}* on the shared lambda/alpha/beta SRAM
//   datapath. Exits on a clean syndrome or after LOOP_MAX iterations and
//   presents the result through o_val/i_rdy.
//
//   Ports
//     clk   : clock, rising edge
//     xrst  : asynchronous active-low reset
//     bus   : ldpc_iter_sched_if.slave (frame request, phase start/done,
//             result handshake, o_loop, o_fail, o_dbg_state [, o_wdog])
//
//   Parameters
//     LOOP_MAX     : max iterations per frame, 1..127
//     WDOG_CYCLES  : per-phase watchdog limit in cycles, 2..65536
//                    (effective only with ITER_SCHED_WDOG_EN)
//
//   Optional feature macro: ITER_SCHED_WDOG_EN
//     Adds a 16-bit phase timer. If a phase sits WDOG_CYCLES cycles without
//     its done, the frame is aborted to OUT with o_fail=1 and o_wdog pulses
//     in that last phase cycle.
//
//   State encoding seen on o_dbg_state:
//     0 IDLE, 1 LOAD, 2 ROW, 3 EST, 4 COL, 5 OUT
// ---------------------------------------------------------------------------
module ldpc_iter_sched #(
  parameter int LOOP_MAX    = 10,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               xrst,
  ldpc_iter_sched_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_ROW  = 3'd2,
    S_EST  = 3'd3,
    S_COL  = 3'd4,
    S_OUT  = 3'd5
  } state_t;

  localparam logic [6:0] LOOP_LAST = 7'(LOOP_MAX);

  // Out-of-range parameters leave a clearly named scope in the hierarchy.
  if (LOOP_MAX < 1 || LOOP_MAX > 127 || WDOG_CYCLES < 2 || WDOG_CYCLES > 65536)
  begin : g_invalid_params
  end

  state_t     r_state;
  logic       r_first;       // first cycle of a phase state: done is ignored
  logic       r_load_start;
  logic       r_row_start;
  logic       r_est_start;
  logic       r_col_start;
  logic [6:0] r_loop;
  logic       r_fail;

  logic       w_done_ok;     // matching done accepted this cycle
  logic [6:0] w_loop_inc;    // saturating o_loop + 1

`ifdef ITER_SCHED_WDOG_EN
  localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES - 1);

  logic [15:0] r_wdog_cnt;
  logic        w_in_phase;
  logic        w_wdog_hit;

  assign w_in_phase = (r_state == S_LOAD) || (r_state == S_ROW) ||
                      (r_state == S_EST)  || (r_state == S_COL);
  // A done arriving in the limit cycle still wins over the watchdog.
  assign w_wdog_hit = w_in_phase && (r_wdog_cnt == WDOG_LAST) && !w_done_ok;
  assign bus.o_wdog = w_wdog_hit;
`endif

  always_comb begin
    w_done_ok = 1'b0;
    case (r_state)
      S_LOAD:  w_done_ok = bus.i_load_done;
      S_ROW:   w_done_ok = bus.i_row_done;
      S_EST:   w_done_ok = bus.i_est_done;
      S_COL:   w_done_ok = bus.i_col_done;
      default: w_done_ok = 1'b0;
    endcase
    // A done coinciding with the start pulse belongs to an earlier request.
    if (r_first) w_done_ok = 1'b0;
  end

  assign w_loop_inc = (r_loop == 7'd127) ? r_loop : (r_loop + 7'd1);

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_state      <= S_IDLE;
      r_first      <= 1'b0;
      r_load_start <= 1'b0;
      r_row_start  <= 1'b0;
      r_est_start  <= 1'b0;
      r_col_start  <= 1'b0;
      r_loop       <= 7'd0;
      r_fail       <= 1'b0;
`ifdef ITER_SCHED_WDOG_EN
      r_wdog_cnt   <= 16'd0;
`endif
    end else begin
      // Start pulses and the entry flag live for exactly one cycle.
      r_first      <= 1'b0;
      r_load_start <= 1'b0;
      r_row_start  <= 1'b0;
      r_est_start  <= 1'b0;
      r_col_start  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (bus.i_val) begin
            r_state      <= S_LOAD;
            r_first      <= 1'b1;
            r_load_start <= 1'b1;
            r_loop       <= 7'd0;
            r_fail       <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_done_ok) begin
            r_state     <= S_ROW;
            r_first     <= 1'b1;
            r_row_start <= 1'b1;
          end
        end
        S_ROW: begin
          if (w_done_ok) begin
            r_state     <= S_EST;
            r_first     <= 1'b1;
            r_est_start <= 1'b1;
          end
        end
        S_EST: begin
          if (w_done_ok) begin
            r_loop <= w_loop_inc;
            if (bus.i_parity_ok) begin
              r_state <= S_OUT;
              r_fail  <= 1'b0;
            end else if (w_loop_inc == LOOP_LAST) begin
              r_state <= S_OUT;
              r_fail  <= 1'b1;
            end else begin
              r_state     <= S_COL;
              r_first     <= 1'b1;
              r_col_start <= 1'b1;
            end
          end
        end
        S_COL: begin
          if (w_done_ok) begin
            r_state     <= S_ROW;
            r_first     <= 1'b1;
            r_row_start <= 1'b1;
          end
        end
        S_OUT: begin
          if (bus.i_rdy) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

`ifdef ITER_SCHED_WDOG_EN
      // Watchdog abort keeps o_loop as counted so far.
      if (w_wdog_hit) begin
        r_state <= S_OUT;
        r_fail  <= 1'b1;
      end
      // Timer restarts on every state change and idles at zero outside phases.
      r_wdog_cnt <= (w_in_phase && !w_done_ok && !w_wdog_hit) ?
                    (r_wdog_cnt + 16'd1) : 16'd0;
`endif
    end
  end

  assign bus.o_rdy        = (r_state == S_IDLE);
  assign bus.o_val        = (r_state == S_OUT);
  assign bus.o_load_start = r_load_start;
  assign bus.o_row_start  = r_row_start;
  assign bus.o_est_start  = r_est_start;
  assign bus.o_col_start  = r_col_start;
  assign bus.o_loop       = r_loop;
  assign bus.o_fail       = r_fail;
  assign bus.o_dbg_state  = r_state;

endmodule

// File: tb/tb_ldpc_iter_sched.sv
module tb_ldpc_iter_sched;
  localparam int LOOP_MAX = 4;
  localparam int WDOG     = 16;

  logic clk  = 1'b0;
  logic xrst = 1'b0;

  ldpc_iter_sched_if bus();

  ldpc_iter_sched #(.LOOP_MAX(LOOP_MAX), .WDOG_CYCLES(WDOG)) dut (
    .clk  (clk),
    .xrst (xrst),
    .bus  (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];   // expected {fail, loop} of each finished frame

  // Start-pulse counters, sampled mid-cycle.
  int n_load = 0, n_row = 0, n_est = 0, n_col = 0;
  always @(negedge clk) begin
    if (bus.o_load_start) n_load++;
    if (bus.o_row_start)  n_row++;
    if (bus.o_est_start)  n_est++;
    if (bus.o_col_start)  n_col++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_val       = 1'b0;
    bus.i_load_done = 1'b0;
    bus.i_row_done  = 1'b0;
    bus.i_est_done  = 1'b0;
    bus.i_parity_ok = 1'b0;
    bus.i_col_done  = 1'b0;
    bus.i_rdy       = 1'b0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    xrst = 1'b0;
    tick();
    tick();
    xrst = 1'b1;
    tick();
  endtask

  // From IDLE: after return we are in the first LOAD cycle.
  task automatic accept();
    bus.i_val = 1'b1;
    tick();
    bus.i_val = 1'b0;
  endtask

  // From the first cycle of a phase: done in its second cycle.
  // which: 0 load, 1 row, 2 est, 3 col. Returns in the first cycle of the next state.
  task automatic give_done(input int which, input bit par);
    tick();
    case (which)
      0: bus.i_load_done = 1'b1;
      1: bus.i_row_done  = 1'b1;
      2: begin bus.i_est_done = 1'b1; bus.i_parity_ok = par; end
      default: bus.i_col_done = 1'b1;
    endcase
    tick();
    bus.i_load_done = 1'b0;
    bus.i_row_done  = 1'b0;
    bus.i_est_done  = 1'b0;
    bus.i_parity_ok = 1'b0;
    bus.i_col_done  = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] b;
    clear_inputs();
    xrst = 1'b0;
    tick();
    checks++;
    if ({bus.o_rdy, bus.o_val, bus.o_loop, bus.o_fail} !== {1'b1, 1'b0, 7'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_idle: rdy=%0b val=%0b loop=%0d fail=%0b, expected 1 0 0 0",
               bus.o_rdy, bus.o_val, bus.o_loop, bus.o_fail);
    end
    xrst = 1'b1;
    tick();
    // Reset mid-ROW in the second iteration (o_loop already 1).
    accept();
    give_done(0, 1'b0);
    give_done(1, 1'b0);
    give_done(2, 1'b0);
    give_done(3, 1'b0);
    tick();
    b = {1'b0, bus.o_loop};
    checks++;
    if (bus.o_dbg_state !== 3'd2 || b !== 8'd1) begin
      errors++;
      $display("FAIL reset_pre_row: state=%0d loop=%0d, expected 2 1", bus.o_dbg_state, bus.o_loop);
    end
    #2 xrst = 1'b0;
    #1;
    checks++;
    if ({bus.o_rdy, bus.o_val, bus.o_loop, bus.o_fail, bus.o_dbg_state} !==
        {1'b1, 1'b0, 7'd0, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL reset_async: rdy=%0b val=%0b loop=%0d fail=%0b state=%0d, expected 1 0 0 0 0",
               bus.o_rdy, bus.o_val, bus.o_loop, bus.o_fail, bus.o_dbg_state);
    end
    checks++;
    if ({bus.o_load_start, bus.o_row_start, bus.o_est_start, bus.o_col_start} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_starts: starts=%b, expected 0000",
               {bus.o_load_start, bus.o_row_start, bus.o_est_start, bus.o_col_start});
    end
    tick();
    xrst = 1'b1;
    tick();
    checks++;
    if ({bus.o_rdy, bus.o_dbg_state} !== {1'b1, 3'd0}) begin
      errors++;
      $display("FAIL reset_release: rdy=%0b state=%0d, expected 1 0", bus.o_rdy, bus.o_dbg_state);
    end
  endtask

  task automatic test_early_exit();
    int b_col;
    logic [7:0] e;
    reset_dut();
    b_col = n_col;
    exp_q.push_back({1'b0, 7'd1});
    accept();
    checks++;
    if ({bus.o_load_start, bus.o_dbg_state} !== {1'b1, 3'd1}) begin
      errors++;
      $display("FAIL early_load_start: start=%0b state=%0d, expected 1 1", bus.o_load_start, bus.o_dbg_state);
    end
    give_done(0, 1'b0);
    checks++;
    if (bus.o_row_start !== 1'b1) begin
      errors++;
      $display("FAIL early_row_start: got %0b expected 1", bus.o_row_start);
    end
    give_done(1, 1'b0);
    checks++;
    if (bus.o_est_start !== 1'b1) begin
      errors++;
      $display("FAIL early_est_start: got %0b expected 1", bus.o_est_start);
    end
    give_done(2, 1'b1);
    e = exp_q.pop_front();
    checks++;
    if ({bus.o_val, bus.o_fail, bus.o_loop} !== {1'b1, e}) begin
      errors++;
      $display("FAIL early_out: val=%0b fail=%0b loop=%0d, expected 1 %0b %0d",
               bus.o_val, bus.o_fail, bus.o_loop, e[7], e[6:0]);
    end
    checks++;
    if (n_col - b_col !== 0) begin
      errors++;
      $display("FAIL early_col_pulses: got %0d expected 0", n_col - b_col);
    end
    bus.i_rdy = 1'b1;
    tick();
    bus.i_rdy = 1'b0;
    checks++;
    if ({bus.o_rdy, bus.o_val} !== 2'b10) begin
      errors++;
      $display("FAIL early_release: rdy=%0b val=%0b, expected 1 0", bus.o_rdy, bus.o_val);
    end
  endtask

  // Leaves the DUT in the first OUT cycle for the backpressure test.
  task automatic test_max_loop();
    int b_load, b_row, b_est, b_col;
    logic [7:0] e;
    reset_dut();
    b_load = n_load; b_row = n_row; b_est = n_est; b_col = n_col;
    exp_q.push_back({1'b1, 7'd4});
    accept();
    give_done(0, 1'b0);
    for (int it = 1; it <= LOOP_MAX; it++) begin
      give_done(1, 1'b0);
      give_done(2, 1'b0);
      if (it == 1) begin
        checks++;
        if ({bus.o_col_start, bus.o_loop} !== {1'b1, 7'd1}) begin
          errors++;
          $display("FAIL max_first_col: col_start=%0b loop=%0d, expected 1 1", bus.o_col_start, bus.o_loop);
        end
      end
      if (it < LOOP_MAX) give_done(3, 1'b0);
    end
    e = exp_q.pop_front();
    checks++;
    if ({bus.o_val, bus.o_fail, bus.o_loop} !== {1'b1, e}) begin
      errors++;
      $display("FAIL max_out: val=%0b fail=%0b loop=%0d, expected 1 %0b %0d",
               bus.o_val, bus.o_fail, bus.o_loop, e[7], e[6:0]);
    end
    checks++;
    if ((n_load - b_load) !== 1 || (n_row - b_row) !== 4 || (n_est - b_est) !== 4 || (n_col - b_col) !== 3) begin
      errors++;
      $display("FAIL max_pulses: load=%0d row=%0d est=%0d col=%0d, expected 1 4 4 3",
               n_load - b_load, n_row - b_row, n_est - b_est, n_col - b_col);
    end
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < 5; c++) begin
      bus.i_val      = 1'b1;
      bus.i_est_done = 1'b1;
      bus.i_row_done = c[0];
      tick();
      checks++;
      if ({bus.o_val, bus.o_rdy, bus.o_loop, bus.o_fail, bus.o_dbg_state} !==
          {1'b1, 1'b0, 7'd4, 1'b1, 3'd5}) begin
        errors++;
        $display("FAIL bp_hold_%0d: val=%0b rdy=%0b loop=%0d fail=%0b state=%0d, expected 1 0 4 1 5",
                 c, bus.o_val, bus.o_rdy, bus.o_loop, bus.o_fail, bus.o_dbg_state);
      end
    end
    clear_inputs();
    bus.i_rdy = 1'b1;
    tick();
    bus.i_rdy = 1'b0;
    checks++;
    if ({bus.o_rdy, bus.o_val, bus.o_loop, bus.o_fail} !== {1'b1, 1'b0, 7'd4, 1'b1}) begin
      errors++;
      $display("FAIL bp_release: rdy=%0b val=%0b loop=%0d fail=%0b, expected 1 0 4 1",
               bus.o_rdy, bus.o_val, bus.o_loop, bus.o_fail);
    end
    accept();
    checks++;
    if ({bus.o_load_start, bus.o_loop, bus.o_fail} !== {1'b1, 7'd0, 1'b0}) begin
      errors++;
      $display("FAIL bp_reaccept: load_start=%0b loop=%0d fail=%0b, expected 1 0 0",
               bus.o_load_start, bus.o_loop, bus.o_fail);
    end
  endtask

  task automatic test_spurious();
    reset_dut();
    // Done and ready while idle: nothing happens.
    bus.i_load_done = 1'b1; bus.i_row_done = 1'b1; bus.i_est_done = 1'b1;
    bus.i_col_done  = 1'b1; bus.i_rdy = 1'b1;
    tick();
    clear_inputs();
    checks++;
    if ({bus.o_dbg_state, bus.o_load_start} !== {3'd0, 1'b0}) begin
      errors++;
      $display("FAIL spur_idle: state=%0d load_start=%0b, expected 0 0", bus.o_dbg_state, bus.o_load_start);
    end
    accept();
    bus.i_load_done = 1'b1;   // same cycle as o_load_start
    tick();
    bus.i_load_done = 1'b0;
    checks++;
    if ({bus.o_dbg_state, bus.o_row_start} !== {3'd1, 1'b0}) begin
      errors++;
      $display("FAIL spur_load_first: state=%0d row_start=%0b, expected 1 0", bus.o_dbg_state, bus.o_row_start);
    end
    bus.i_load_done = 1'b1;
    tick();
    bus.i_load_done = 1'b0;
    tick();                   // second ROW cycle
    bus.i_col_done = 1'b1; bus.i_est_done = 1'b1; bus.i_load_done = 1'b1;
    tick();
    clear_inputs();
    checks++;
    if ({bus.o_dbg_state, bus.o_est_start} !== {3'd2, 1'b0}) begin
      errors++;
      $display("FAIL spur_row: state=%0d est_start=%0b, expected 2 0", bus.o_dbg_state, bus.o_est_start);
    end
    bus.i_row_done = 1'b1;
    tick();
    bus.i_row_done = 1'b0;
    bus.i_est_done = 1'b1; bus.i_parity_ok = 1'b1;   // in the est_start cycle
    tick();
    clear_inputs();
    checks++;
    if ({bus.o_dbg_state, bus.o_val, bus.o_loop} !== {3'd3, 1'b0, 7'd0}) begin
      errors++;
      $display("FAIL spur_est_first: state=%0d val=%0b loop=%0d, expected 3 0 0",
               bus.o_dbg_state, bus.o_val, bus.o_loop);
    end
    bus.i_row_done = 1'b1; bus.i_col_done = 1'b1;
    tick();
    clear_inputs();
    checks++;
    if (bus.o_dbg_state !== 3'd3) begin
      errors++;
      $display("FAIL spur_est: state=%0d expected 3", bus.o_dbg_state);
    end
    bus.i_est_done = 1'b1;
    tick();
    clear_inputs();
    checks++;
    if ({bus.o_dbg_state, bus.o_col_start, bus.o_loop} !== {3'd4, 1'b1, 7'd1}) begin
      errors++;
      $display("FAIL spur_to_col: state=%0d col_start=%0b loop=%0d, expected 4 1 1",
               bus.o_dbg_state, bus.o_col_start, bus.o_loop);
    end
  endtask

`ifdef ITER_SCHED_WDOG_EN
  task automatic test_watchdog();
    reset_dut();
    accept();
    give_done(0, 1'b0);
    give_done(1, 1'b0);
    give_done(2, 1'b0);       // first COL cycle
    for (int c = 1; c <= WDOG; c++) begin
      checks++;
      if (bus.o_wdog !== (c == WDOG)) begin
        errors++;
        $display("FAIL wdog_cycle_%0d: got %0b expected %0b", c, bus.o_wdog, (c == WDOG));
      end
      if (c < WDOG) tick();
    end
    tick();
    checks++;
    if ({bus.o_val, bus.o_fail, bus.o_loop, bus.o_wdog} !== {1'b1, 1'b1, 7'd1, 1'b0}) begin
      errors++;
      $display("FAIL wdog_out: val=%0b fail=%0b loop=%0d wdog=%0b, expected 1 1 1 0",
               bus.o_val, bus.o_fail, bus.o_loop, bus.o_wdog);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_early_exit();
    test_max_loop();
    test_backpressure();
    test_spurious();
`ifdef ITER_SCHED_WDOG_EN
    test_watchdog();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
